// File: rtl/result_collector.sv
// rtl/result_collector.sv - collects serialized array results into one matrix and hands it downstream.
// Optional: define RESULT_COLLECTOR_RELU_EN to clamp negative words to zero at capture.
module result_collector #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  localparam int num_words_lp  = array_width_p * array_height_p,
  localparam int idx_w_lp      = (num_words_lp > 1) ? $clog2(num_words_lp) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              en_i,
  input  logic                              start_i,
  output logic                              flush_o,
  input  logic                              valid_i,
  input  logic [width_p-1:0]                data_i,
  output logic                              yumi_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [width_p*num_words_lp-1:0]   matrix_o,
  output logic                              busy_o,
  output logic [idx_w_lp:0]                 count_o
);

  localparam logic [3:0] IDLE_S    = 4'b0001;
  localparam logic [3:0] FLUSH_S   = 4'b0010;
  localparam logic [3:0] COLLECT_S = 4'b0100;
  localparam logic [3:0] PRESENT_S = 4'b1000;

  localparam logic [idx_w_lp:0] last_idx_lp = (idx_w_lp + 1)'(num_words_lp - 1);
  localparam logic [idx_w_lp:0] max_cnt_lp  = (idx_w_lp + 1)'(num_words_lp);

  logic [3:0]                            state_q, state_d;
  logic [idx_w_lp:0]                     count_q, count_d;
  logic [width_p*num_words_lp-1:0]       mat_q, mat_d;
  logic [width_p-1:0]                    word_in;
  logic                                  capture;

`ifdef RESULT_COLLECTOR_RELU_EN
  assign word_in = data_i[width_p-1] ? '0 : data_i;
`else
  assign word_in = data_i;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mat_d   = mat_q;
    capture = 1'b0;
    if (en_i) begin
      case (state_q)
        IDLE_S: begin
          if (start_i) begin
            state_d = FLUSH_S;
            count_d = '0;
          end
        end
        FLUSH_S: state_d = COLLECT_S;
        COLLECT_S: begin
          if (valid_i) begin
            capture = 1'b1;
            for (int k = 0; k < num_words_lp; k++) begin
              if (count_q == (idx_w_lp + 1)'(k)) begin
                mat_d[k*width_p +: width_p] = word_in;
              end
            end
            if (count_q < max_cnt_lp) begin
              count_d = count_q + 1'b1;
            end
            if (count_q == last_idx_lp) begin
              state_d = PRESENT_S;
            end
          end
        end
        PRESENT_S: begin
          if (ready_i) begin
            state_d = IDLE_S;
            count_d = '0;
          end
        end
        default: state_d = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE_S;
      count_q <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mat_q   <= mat_d;
    end
  end

  assign flush_o  = en_i && (state_q == FLUSH_S);
  assign yumi_o   = capture;
  assign valid_o  = (state_q == PRESENT_S);
  assign matrix_o = mat_q;
  assign busy_o   = (state_q != IDLE_S);
  assign count_o  = count_q;

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - vector table, directed corner sequences and randomized transactions vs a reference model.
module tb_result_collector;

  logic         clk = 1'b0;
  logic         reset_ni, en_i, start_i, valid_i, ready_i;
  logic [31:0]  data_i;
  logic         flush_o, yumi_o, valid_o, busy_o;
  logic [127:0] matrix_o;
  logic [2:0]   count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  result_collector dut (
    .clk_i(clk), .reset_ni(reset_ni), .en_i(en_i), .start_i(start_i),
    .flush_o(flush_o), .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o),
    .valid_o(valid_o), .ready_i(ready_i), .matrix_o(matrix_o),
    .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] words;
    int           gap;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: what the buffer should hold for a given raw word.
  function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef RESULT_COLLECTOR_RELU_EN
    return ($signed(w) < 0) ? 32'd0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] ref_matrix(input logic [127:0] words);
    logic [127:0] m;
    for (int k = 0; k < 4; k++) m[k*32 +: 32] = ref_word(words[k*32 +: 32]);
    return m;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic [127:0] words, input int gap, input int hold,
                         input logic [127:0] exp, input string tag);
    start_i = 1'b1;
    #1 check({tag, ".idle_flush"}, flush_o, 0);
    @(negedge clk);
    start_i = 1'b0;
    #1 check({tag, ".flush"}, flush_o, 1);
    check({tag, ".busy"}, busy_o, 1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        valid_i = 1'b0;
        #1 check({tag, ".gap_yumi"}, yumi_o, 0);
        @(negedge clk);
      end
      valid_i = 1'b1;
      data_i  = words[k*32 +: 32];
      #1 check({tag, ".yumi"}, yumi_o, 1);
      check({tag, ".count"}, count_o, k);
      check({tag, ".flush_low"}, flush_o, 0);
      if (k > 0) check({tag, ".partial"}, matrix_o[(k-1)*32 +: 32], exp[(k-1)*32 +: 32]);
      @(negedge clk);
    end
    data_i = 32'hDEAD;
    for (int h = 0; h <= hold; h++) begin
      ready_i = (h == hold);
      #1 check({tag, ".valid_o"}, valid_o, 1);
      check({tag, ".present_yumi"}, yumi_o, 0);
      check({tag, ".matrix"}, matrix_o, exp);
      check({tag, ".count_full"}, count_o, 4);
      @(negedge clk);
    end
    ready_i = 1'b0;
    valid_i = 1'b0;
    #1 check({tag, ".busy_after"}, busy_o, 0);
    check({tag, ".valid_after"}, valid_o, 0);
    check({tag, ".count_after"}, count_o, 0);
    check({tag, ".matrix_hold"}, matrix_o, exp);
    @(negedge clk);
  endtask

  initial begin
    reset_ni = 1'b0; en_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;

    vecs[0] = '{128'h00000044_00000033_00000022_00000011, 0, 0,
                128'h00000044_00000033_00000022_00000011};
`ifdef RESULT_COLLECTOR_RELU_EN
    vecs[1] = '{128'h7FFFFFFF_80000000_00000005_FFFFFFFF, 0, 1,
                128'h7FFFFFFF_00000000_00000005_00000000};
    vecs[2] = '{128'h00000000_12345678_A5A5A5A5_0000FFFF, 2, 10,
                128'h00000000_12345678_00000000_0000FFFF};
    vecs[3] = '{128'h01020304_F0000000_00000001_7FFFFFFE, 1, 3,
                128'h01020304_00000000_00000001_7FFFFFFE};
`else
    vecs[1] = '{128'h7FFFFFFF_80000000_00000005_FFFFFFFF, 0, 1,
                128'h7FFFFFFF_80000000_00000005_FFFFFFFF};
    vecs[2] = '{128'h00000000_12345678_A5A5A5A5_0000FFFF, 2, 10,
                128'h00000000_12345678_A5A5A5A5_0000FFFF};
    vecs[3] = '{128'h01020304_F0000000_00000001_7FFFFFFE, 1, 3,
                128'h01020304_F0000000_00000001_7FFFFFFE};
`endif

    @(negedge clk);
    #1 check("rst.busy", busy_o, 0);
    check("rst.valid", valid_o, 0);
    check("rst.flush", flush_o, 0);
    check("rst.yumi", yumi_o, 0);
    check("rst.count", count_o, 0);
    check("rst.matrix", matrix_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);

    // valid_i in IDLE must be ignored
    valid_i = 1'b1; data_i = 32'hBEEF;
    for (int i = 0; i < 2; i++) begin
      #1 check("idle.yumi", yumi_o, 0);
      check("idle.count", count_o, 0);
      check("idle.busy", busy_o, 0);
      @(negedge clk);
    end
    valid_i = 1'b0;

    for (int v = 0; v < 4; v++) run_txn(vecs[v].words, vecs[v].gap, vecs[v].hold, vecs[v].exp, $sformatf("vec%0d", v));

    // Asynchronous reset after two captured words
    start_i = 1'b1; @(negedge clk); start_i = 1'b0; @(negedge clk);
    valid_i = 1'b1; data_i = 32'h0000_0101; @(negedge clk);
    data_i = 32'h0000_0202; @(negedge clk);
    valid_i = 1'b0;
    #1 check("arst.count_pre", count_o, 2);
    #2 reset_ni = 1'b0;
    #1 check("arst.busy", busy_o, 0);
    check("arst.valid", valid_o, 0);
    check("arst.count", count_o, 0);
    check("arst.matrix", matrix_o, 0);
    check("arst.flush", flush_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    run_txn(vecs[0].words, 0, 0, vecs[0].exp, "arst_rerun");

    // en_i gating in FLUSH_S and COLLECT_S, plus start_i ignored while collecting
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("en.flush_off", flush_o, 0);
      check("en.busy", busy_o, 1);
      @(negedge clk);
    end
    en_i = 1'b1;
    #1 check("en.flush_on", flush_o, 1);
    @(negedge clk);
    start_i = 1'b1; valid_i = 1'b1; data_i = 32'h55; en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("en.yumi_off", yumi_o, 0);
      check("en.count_hold", count_o, 0);
      @(negedge clk);
    end
    en_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_i = 32'h55 + 32'h11 * k;
      #1 check("en.yumi", yumi_o, 1);
      check("en.no_reflush", flush_o, 0);
      check("en.count", count_o, k);
      @(negedge clk);
    end
    start_i = 1'b0; valid_i = 1'b0;
    #1 check("en.matrix", matrix_o, 128'h00000088_00000077_00000066_00000055);
    check("en.valid", valid_o, 1);
    // start_i coincident with the handoff is dropped
    ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0; start_i = 1'b0;
    #1 check("hs_start.busy", busy_o, 0);
    @(negedge clk);
    #1 check("hs_start.busy2", busy_o, 0);
    check("hs_start.flush", flush_o, 0);
    @(negedge clk);

    // Randomized transactions against the reference model
    for (int t = 0; t < 8; t++) begin
      logic [127:0] w;
      w = {$urandom, $urandom, $urandom, $urandom};
      run_txn(w, $urandom_range(0, 3), $urandom_range(0, 4), ref_matrix(w), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
